fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end upstream of decode: owns the fetch PC, issues in-order word reads to instruction memory over req/gnt/rvalid, and buffers returned instructions with their PC.
//  Presents {instr, pc} to decode via valid/ready. Redirect (taken branch/jump) restarts fetch and discards stale in-flight data.
// PARAMETERS
//  DEPTH            4        queue entries ({pc,instr} pairs); power of two, >=2
//  MAX_OUTSTANDING  2        max granted-but-unreturned memory reads
//  RESET_PC         32'h0    first fetch address after reset (word aligned)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   read request; address valid while high
//  imem_addr    out  32  word-aligned fetch address
//  imem_gnt     in   1   request accepted this cycle (sampled only with imem_req=1)
//  imem_rvalid  in   1   read data valid; responses strictly in grant order
//  imem_rdata   in   32  instruction word
//  redirect     in   1   one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch address; bits [1:0] ignored (forced 0)
//  halt         in   1   level: issue no new requests; queue still drains
//  out_valid    out  1   queue head valid
//  out_ready    in   1   decode accepts head this cycle
//  out_instr    out  32  head instruction
//  out_pc       out  32  PC of head instruction
//  occupancy    out  $clog2(DEPTH)+1  entries currently held
// BEHAVIOUR
//  Reset: imem_req=0, imem_addr=RESET_PC, out_valid=0, occupancy=0, outstanding=0, discard=0, state=BOOT.
//  FSM: BOOT -> FETCH after one cycle. FETCH -> WAIT when credit=0 or halt=1; WAIT -> FETCH when credit>0 and halt=0. Redirect from any state -> FETCH.
//  credit = (occupancy + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING); imem_req = (state==FETCH) && credit && !halt.
//  Req handshake: imem_addr stable while imem_req=1 and no gnt; on req&gnt: outstanding+1, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0).
//  Response: imem_rvalid with discard=0 -> push {fetch-order pc, rdata}, outstanding-1; with discard>0 -> drop, discard-1, outstanding-1.
//  Push is never refused: credit guarantees space. rvalid with outstanding=0 is a protocol error (assertion).
//  Pop on out_valid&out_ready. Push+pop same cycle: occupancy unchanged, full queue stays consistent.
//  Latency (no bypass): response accepted at edge N -> out_valid=1 in cycle N+1; 1 pop/cycle max throughput.
//  Redirect (at edge): queue cleared, fetch_pc <= {redirect_pc[31:2],2'b00}, discard <= outstanding (+1 if req&gnt same cycle), any push that cycle dropped.
//  Pop in the redirect cycle is honoured (decode consumed it). Un-granted request in redirect cycle is abandoned; new address from next cycle.
//  Redirect while discard>0: discard accumulates, never drops below true stale count; first new-address response is first kept.
//  halt: only blocks new requests; outstanding responses still land/are discarded.
//  Reset mid-operation: all state cleared asynchronously; late responses after reset release ignored (outstanding=0 ⇒ assertion only in sim).
// CONFIGURATION
//  FETCHQ_BYPASS_EN defined: when queue empty and kept response arrives, out_valid/out_instr/out_pc driven combinationally from imem_rdata same cycle; if out_ready, entry not stored (0-cycle latency). Redirect cycle suppresses bypass.
//  Not defined: all responses go through queue; outputs purely registered/FIFO-read (1-cycle latency).
// STRUCTURE
//  Package mips_fetch_pkg: INSTR_W=32, PC_W=32, PC_INC=4, fetch_state_t {BOOT,FETCH,WAIT}, fetch_entry_t {pc,instr}.
//  Sub-module fetchq_fifo: sync FIFO of fetch_entry_t, DEPTH entries, push/pop/clear, count, async active-low reset.
//  Separate PC FIFO (MAX_OUTSTANDING deep) of granted addresses supplies pc for each response.
// TESTING
//  1 Reset, gnt=1, rvalid 1 cycle after gnt, out_ready=1 -> pc 0,4,8,... in order, one instr/cycle after fill.
//  2 out_ready=0 -> occupancy reaches DEPTH(4), imem_req drops, state WAIT; ready=1 resumes with no loss/duplication.
//  3 Redirect to 32'h100 with 2 outstanding -> both stale responses dropped, first out_pc=32'h100, queue empty next cycle.
//  4 redirect_pc=32'h203 -> imem_addr=32'h200; fetch from 32'hFFFF_FFFC -> next addr 32'h0.
//  5 gnt held low 5 cycles -> imem_addr stable; halt=1 -> no req, queued entries still drain.
//  6 FETCHQ_BYPASS_EN, empty queue, rvalid with out_ready=1 -> out_valid same cycle, occupancy stays 0; undefined -> out_valid next cycle.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// mips_fetch_pkg: shared widths, FSM state type and queue entry type for the fetch queue.
//   INSTR_W / PC_W : instruction and PC widths
//   PC_INC         : sequential fetch stride in bytes
//   fetch_state_t  : BOOT / FETCH / WAIT
//   fetch_entry_t  : {pc, instr} pair held by the queue
package mips_fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Clear the byte-offset bits of a fetch address.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: groups the instruction-memory bus and the decode-side valid/ready channel.
//   imem_req/imem_addr (to memory), imem_gnt/imem_rvalid/imem_rdata (from memory)
//   out_valid/out_instr/out_pc (to decode), out_ready (from decode)
//   modport master : the fetch queue
//   modport slave  : memory + decode environment
interface fetch_queue_if;
    import mips_fetch_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_gnt, imem_rvalid, imem_rdata, out_ready
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// fetchq_fifo: synchronous FIFO, DEPTH entries of type T, async active-low reset.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : drop all contents (and any push) this cycle
//   push/wdata      : write an entry (ignored when full unless popping)
//   pop/rdata       : rdata is the head entry; pop removes it
//   count/empty/full: fill level
module fetchq_fifo
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  T                         wdata,
    input  logic                     pop,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    T mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Owns the fetch PC, issues in-order word reads over
// req/gnt/rvalid, buffers {pc, instr} and presents them to decode via valid/ready.
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus (master)          : imem_* memory bus and out_* decode channel
//   redirect/redirect_pc  : one-cycle restart of fetch at a new address
//   halt                  : block new requests; queue keeps draining
//   occupancy             : entries currently held in the queue
// Build option: define FETCHQ_BYPASS_EN to forward a kept response straight to decode when the
// queue is empty (zero-cycle latency); otherwise every response goes through the queue.
module fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [PC_W-1:0] RESET_PC        = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fetch_queue_if.master          bus,
    input  logic                   redirect,
    input  logic [PC_W-1:0]        redirect_pc,
    input  logic                   halt,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

    fetch_state_t    state_q;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]   discard_q, discard_d;
    logic [OW-1:0]   outstanding, outstanding_next;
    logic [31:0]     inflight;
    logic            credit, req, grant, rsp, keep, drop;
    logic            q_push, q_pop, q_empty, q_full;
    logic            pc_empty, pc_full;
    fetch_entry_t    q_rdata, q_wdata;
    logic [PC_W-1:0] pc_head;

    assign inflight = 32'(occupancy) + 32'(outstanding);
    assign credit   = (inflight < DEPTH) && !pc_full;
    assign req      = (state_q == FETCH) && credit && !halt;
    assign grant    = req && bus.imem_gnt;
    // A response with nothing in flight (e.g. straggler after reset) is ignored.
    assign rsp      = bus.imem_rvalid && !pc_empty;
    assign keep     = rsp && (discard_q == '0);
    assign drop     = rsp && (discard_q != '0);

    assign outstanding_next = outstanding + OW'(grant) - OW'(rsp);

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_q;
    assign q_wdata       = '{pc: pc_head, instr: bus.imem_rdata};

`ifdef FETCHQ_BYPASS_EN
    logic byp;
    assign byp           = keep && q_empty && !redirect;
    assign bus.out_valid = !q_empty || byp;
    assign bus.out_pc    = q_empty ? pc_head : q_rdata.pc;
    assign bus.out_instr = q_empty ? bus.imem_rdata : q_rdata.instr;
    assign q_push        = keep && !redirect && !(byp && bus.out_ready);
    assign q_pop         = !q_empty && bus.out_ready;
`else
    assign bus.out_valid = !q_empty;
    assign bus.out_pc    = q_rdata.pc;
    assign bus.out_instr = q_rdata.instr;
    assign q_push        = keep && !redirect;
    assign q_pop         = bus.out_valid && bus.out_ready;
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
            // Everything still in flight after this edge predates the redirect.
            discard_d  = outstanding_next;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + PC_INC;
            if (drop)  discard_d  = discard_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else if (redirect) begin
            state_q <= FETCH;
        end else begin
            unique case (state_q)
                BOOT:    state_q <= FETCH;
                FETCH:   if (!credit || halt) state_q <= WAIT;
                WAIT:    if (credit && !halt) state_q <= FETCH;
                default: state_q <= BOOT;
            endcase
        end
    end

    fetchq_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_entry_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_rdata),
        .count (occupancy),
        .empty (q_empty),
        .full  (q_full)
    );

    // Granted addresses in order; its head is the PC of the next response.
    fetchq_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (logic [PC_W-1:0])
    ) u_pc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .push  (grant),
        .wdata (fetch_pc_q),
        .pop   (rsp),
        .rdata (pc_head),
        .count (outstanding),
        .empty (pc_empty),
        .full  (pc_full)
    );

    a_rvalid_in_flight: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rvalid |-> !pc_empty);
    a_push_has_space: assert property (@(posedge clk) disable iff (!rst_n)
        q_push |-> (!q_full || q_pop));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import mips_fetch_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int S_BOOT = 0, S_FETCH = 1, S_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [2:0]  occupancy;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // stimulus knobs
    int gnt_pct = 100, rv_pct = 100, rdy_pct = 100;
    bit redir_pend = 0;
    logic [31:0] redir_addr = '0;

    // memory side: granted addresses awaiting a response
    logic [31:0] mem_addr_q[$];
    int          mem_cyc_q[$];

    // reference model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pcq[$];
    int          m_discard;
    logic [31:0] m_fpc;
    int          m_st;

    // observations
    logic [31:0] pops[$];
    int          pop_cycs[$];
    bit          snap_valid, snap_req;
    bit          saw_wrap = 0;
    bit          redir_since_pop = 0;
    bit          have_last = 0;
    logic [31:0] last_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        if (i < pops.size()) return pops[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pcq.delete();
        m_discard = 0;
        m_fpc = RESET_PC;
        m_st = S_BOOT;
        mem_addr_q.delete();
        mem_cyc_q.delete();
        have_last = 0;
    endtask

    // Called at the falling edge: inputs are stable for the coming rising edge.
    task automatic compare_and_advance();
        int occ, outs;
        bit credit, e_req, keep, byp, e_valid, grant, pop, kept;
        logic [31:0] e_pc, rpc;
        occ = m_q.size();
        outs = m_pcq.size();
        credit = (occ + outs < DEPTH) && (outs < MAXO);
        e_req = (m_st == S_FETCH) && credit && !halt;
        keep = bus.imem_rvalid && (m_discard == 0);
        byp = 0;
`ifdef FETCHQ_BYPASS_EN
        byp = keep && (occ == 0) && !redirect;
`endif
        e_valid = (occ > 0) || byp;

        check("imem_req", 32'(bus.imem_req), 32'(e_req));
        check("imem_addr", bus.imem_addr, m_fpc);
        check("out_valid", 32'(bus.out_valid), 32'(e_valid));
        check("occupancy", 32'(occupancy), occ);
        if (e_valid) begin
            e_pc = (occ > 0) ? m_q[0].pc : m_pcq[0];
            check("out_pc", bus.out_pc, e_pc);
            check("out_instr", bus.out_instr, mem_word(e_pc));
        end
        snap_valid = bus.out_valid;
        snap_req = bus.imem_req;

        // Consumed stream must be consecutive words between redirects.
        if (bus.out_valid && bus.out_ready) begin
            if (have_last && !redir_since_pop) check("pc_sequence", bus.out_pc, last_pop + 4);
            pops.push_back(bus.out_pc);
            pop_cycs.push_back(cyc);
            last_pop = bus.out_pc;
            have_last = 1;
            redir_since_pop = 0;
        end
        if (redirect) redir_since_pop = 1;

        if (bus.imem_req && bus.imem_gnt) begin
            mem_addr_q.push_back(bus.imem_addr);
            mem_cyc_q.push_back(cyc);
            if (bus.imem_addr == 32'hFFFF_FFFC) saw_wrap = 1;
        end
        if (bus.imem_rvalid && mem_addr_q.size() > 0) begin
            void'(mem_addr_q.pop_front());
            void'(mem_cyc_q.pop_front());
        end

        grant = e_req && bus.imem_gnt;
        pop = e_valid && bus.out_ready;
        kept = 0;
        rpc = '0;
        if (bus.imem_rvalid && m_pcq.size() > 0) begin
            rpc = m_pcq.pop_front();
            if (m_discard > 0) m_discard--;
            else kept = 1;
        end
        if (redirect) begin
            m_q.delete();
        end else begin
            if (pop && occ > 0) void'(m_q.pop_front());
            if (kept && !(pop && occ == 0)) m_q.push_back(ent_t'{pc: rpc, instr: mem_word(rpc)});
        end
        if (grant) m_pcq.push_back(m_fpc);
        if (redirect) begin
            m_fpc = redirect_pc & ~32'h3;
            m_discard = m_pcq.size();
            m_st = S_FETCH;
        end else begin
            if (grant) m_fpc = m_fpc + 4;
            case (m_st)
                S_BOOT:  m_st = S_FETCH;
                S_FETCH: if (!credit || halt) m_st = S_WAIT;
                default: if (credit && !halt) m_st = S_FETCH;
            endcase
        end
    endtask

    // One clock cycle, entered and left at rising edge + 1.
    task automatic step();
        bus.imem_gnt = ($urandom_range(99) < gnt_pct);
        if (mem_addr_q.size() > 0 && mem_cyc_q[0] < cyc && $urandom_range(99) < rv_pct) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata = mem_word(mem_addr_q[0]);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata = $urandom;
        end
        bus.out_ready = ($urandom_range(99) < rdy_pct);
        redirect = redir_pend;
        redirect_pc = redir_addr;
        redir_pend = 0;
        #4;
        compare_and_advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, "_addr"}, bus.imem_addr, RESET_PC);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_occ"}, 32'(occupancy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 expected below");
        $fatal(1);
    end

    initial begin
        int n;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        cyc = 0;

        // 1: streaming fetch from reset
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        repeat (12) step();
        check("first_pc0", pop_at(0), 32'h0);
        check("first_pc1", pop_at(1), 32'h4);
        check("first_pc2", pop_at(2), 32'h8);
`ifdef FETCHQ_BYPASS_EN
        check("first_pop_cycle", (pop_cycs.size() > 0) ? pop_cycs[0] : -1, 2);
`else
        check("first_pop_cycle", (pop_cycs.size() > 0) ? pop_cycs[0] : -1, 3);
`endif
        for (int k = 0; k < 4; k++)
            check("back_to_back", (pop_cycs.size() > k + 1) ? pop_cycs[k+1] - pop_cycs[k] : -1, 1);

        // 2: back-pressure fills the queue, then resumes
        rdy_pct = 0;
        repeat (10) step();
        check("full_occ", 32'(occupancy), 32'd4);
        check("full_no_req", 32'(bus.imem_req), 32'd0);
        rdy_pct = 100;
        repeat (10) step();

        // 3: redirect with two reads in flight
        rv_pct = 0;
        for (int i = 0; i < 20 && mem_addr_q.size() < 2; i++) step();
        check("two_outstanding", mem_addr_q.size(), 2);
        redir_pend = 1; redir_addr = 32'h100;
        step();
        check("redirect_clear", 32'(occupancy), 32'd0);
        rv_pct = 100;
        n = pops.size();
        for (int i = 0; i < 30 && pops.size() <= n; i++) step();
        check("redirect_first_pc", pop_at(n), 32'h100);

        // 4: alignment and address wrap
        redir_pend = 1; redir_addr = 32'h203;
        step();
        check("redirect_align", bus.imem_addr, 32'h200);
        redir_pend = 1; redir_addr = 32'hFFFF_FFFC;
        saw_wrap = 0;
        for (int i = 0; i < 20 && !saw_wrap; i++) step();
        check("wrap_granted", 32'(saw_wrap), 32'd1);
        check("pc_wrap", bus.imem_addr, 32'h0);

        // 5: grant stall holds the address; halt stops requests but drains
        gnt_pct = 0;
        repeat (8) step();
        n = bus.imem_addr;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_req", 32'(bus.imem_req), 32'd1);
            check("stall_addr", bus.imem_addr, n);
        end
        gnt_pct = 100; rdy_pct = 0;
        repeat (8) step();
        halt = 1; rdy_pct = 100;
        for (int i = 0; i < 20 && occupancy != 0; i++) begin
            step();
            check("halt_no_req", 32'(snap_req), 32'd0);
        end
        check("halt_drain", 32'(occupancy), 32'd0);

        // 6: response latency into an empty queue
        for (int i = 0; i < 20 && mem_addr_q.size() > 0; i++) step();
        halt = 0; rv_pct = 0;
        for (int i = 0; i < 20 && mem_addr_q.size() < 1; i++) step();
        halt = 1;
        check("one_outstanding", mem_addr_q.size(), 1);
        rv_pct = 100;
        step();
`ifdef FETCHQ_BYPASS_EN
        check("bypass_same_cycle", 32'(snap_valid), 32'd1);
        check("bypass_not_stored", 32'(occupancy), 32'd0);
        step();
        check("bypass_then_empty", 32'(snap_valid), 32'd0);
`else
        check("no_bypass_same_cycle", 32'(snap_valid), 32'd0);
        step();
        check("no_bypass_next_cycle", 32'(snap_valid), 32'd1);
`endif
        halt = 0;

        // randomized traffic with a mid-run reset
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                gnt_pct = $urandom_range(20, 100);
                rv_pct = $urandom_range(20, 100);
                rdy_pct = $urandom_range(10, 100);
            end
            if ($urandom_range(99) < 5) halt = ~halt;
            if ($urandom_range(99) < 3) begin
                redir_pend = 1;
                redir_addr = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                      : $urandom;
            end
            if (i == 2000) begin
                halt = 1; rv_pct = 100;
                for (int j = 0; j < 50 && mem_addr_q.size() > 0; j++) step();
                check("pre_reset_drained", mem_addr_q.size(), 0);
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_values("midreset");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                model_reset();
                halt = 0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
